sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; the synchronous-domain successor of the team's dual-clock FIFO.
- Used for buffering inside one clock domain, e.g. between AXI-side datapath stages.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (show-ahead or registered), and sticky overflow/underflow error flags with clear.
- Handshake semantics match the existing FIFO: write gated by full, read gated by empty, flags registered.

---
 rtl/sync_fifo_param.sv | 133 +++++++++++++
 tb/tb_sync_fifo_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, almost-full/empty
// thresholds, show-ahead or registered read data, and sticky error flags.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   wren, wdata       - write request and data (accepted when !wfull)
//   rden, rdata       - read request and data (accepted when !rempty)
//   wfull, rempty     - registered full / empty flags
//   count             - occupancy 0..2**asize
//   almost_full/empty - registered threshold flags
//   overflow/underflow- sticky error flags, cleared by clr_err
module sync_fifo_param #(
    parameter int dsize     = 8,
    parameter int asize     = 4,
    parameter int afull_th  = 12,
    parameter int aempty_th = 2,
    parameter int fwft      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic [dsize-1:0] wdata,
    output logic             wfull,
    input  logic             rden,
    output logic [dsize-1:0] rdata,
    output logic             rempty,
    output logic [asize:0]   count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int depth = 1 << asize;
    localparam logic [asize:0] full_cnt = (asize + 1)'(depth);
    localparam logic [asize:0] afull_c  = (asize + 1)'(afull_th);
    localparam logic [asize:0] aempty_c = (asize + 1)'(aempty_th);

    if (afull_th < 1 || afull_th > depth) begin : g_bad_afull
        $fatal(1, "sync_fifo_param: afull_th out of range 1..2**asize");
    end
    if (aempty_th < 0 || aempty_th > depth - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_param: aempty_th out of range 0..2**asize-1");
    end

    logic [dsize-1:0] mem [depth];
    logic [asize:0]   wptr;
    logic [asize:0]   rptr;
    logic [asize:0]   count_next;
    logic             we_ok;
    logic             re_ok;

    // Accepts look only at registered flags, so there is no
    // combinational path from the requests back into the flags.
    assign we_ok = wren && !wfull;
    assign re_ok = rden && !rempty;

    always_comb begin
        count_next = count;
        if (we_ok && !re_ok) begin
            count_next = count + 1'b1;
        end else if (re_ok && !we_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (we_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (re_ok) begin
                rptr <= rptr + 1'b1;
            end
            count        <= count_next;
            wfull        <= (count_next == full_cnt);
            rempty       <= (count_next == '0);
            almost_full  <= (count_next >= afull_c);
            almost_empty <= (count_next <= aempty_c);
        end
    end

    // A set condition in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren && wfull) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rden && rempty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_ok) begin
            mem[wptr[asize-1:0]] <= wdata;
        end
    end

    if (fwft != 0) begin : g_fwft
        assign rdata = mem[rptr[asize-1:0]];
    end else begin : g_reg
        logic [dsize-1:0] rdata_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (re_ok) begin
                rdata_q <= mem[rptr[asize-1:0]];
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param.
// Two instances share stimulus: u_fw (show-ahead) and u_rg (registered).
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wren;
    logic [7:0] wdata;
    logic       rden;
    logic       clr_err;

    logic       wfull, rempty, afull, aempty, ovf, unf;
    logic [7:0] rdata;
    logic [4:0] count;

    logic       wfull0, rempty0, afull0, aempty0, ovf0, unf0;
    logic [7:0] rdata0;
    logic [4:0] count0;

    int n_chk;
    int n_err;

    sync_fifo_param #(
        .dsize(8), .asize(4), .afull_th(12), .aempty_th(2), .fwft(1)
    ) u_fw (
        .clk(clk), .rst(rst),
        .wren(wren), .wdata(wdata), .wfull(wfull),
        .rden(rden), .rdata(rdata), .rempty(rempty),
        .count(count), .almost_full(afull), .almost_empty(aempty),
        .overflow(ovf), .underflow(unf), .clr_err(clr_err)
    );

    sync_fifo_param #(
        .dsize(8), .asize(4), .afull_th(12), .aempty_th(2), .fwft(0)
    ) u_rg (
        .clk(clk), .rst(rst),
        .wren(wren), .wdata(wdata), .wfull(wfull0),
        .rden(rden), .rdata(rdata0), .rempty(rempty0),
        .count(count0), .almost_full(afull0), .almost_empty(aempty0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests; returns at the following negedge.
    task automatic cyc(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
        wren    = w;
        wdata   = d;
        rden    = r;
        clr_err = c;
        @(posedge clk);
        @(negedge clk);
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic       do_w;
        logic       do_r;
        int         nw;
        int         nr;

        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        wren    = 1'b0;
        rden    = 1'b0;
        wdata   = '0;
        clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. reset state, mid-burst reset
        chk("rst_count", 32'(count), 0);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        chk("rst_rdata_reg", 32'(rdata0), 0);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t1_count5", 32'(count), 5);
        rst = 1'b1;
        #1;
        chk("t1_async_count", 32'(count), 0);
        chk("t1_async_count_reg", 32'(count0), 0);
        chk("t1_async_rempty", 32'(rempty), 1);
        chk("t1_async_wfull", 32'(wfull), 0);
        chk("t1_async_aempty", 32'(aempty), 1);
        chk("t1_async_afull", 32'(afull), 0);
        chk("t1_async_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_a5_count", 32'(count), 1);
        chk("t1_a5_fwft", 32'(rdata), 32'h A5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_a5_reg", 32'(rdata0), 32'h A5);
        chk("t1_empty", 32'(rempty), 1);

        // 2. fill and drain
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("t2_fill_count", 32'(count), 32'(i + 1));
            chk("t2_aempty", 32'(aempty), (i + 1 <= 2) ? 1 : 0);
            chk("t2_afull", 32'(afull), (i + 1 >= 12) ? 1 : 0);
            chk("t2_wfull", 32'(wfull), (i + 1 == 16) ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) begin
            chk("t2_head", 32'(rdata), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t2_reg_data", 32'(rdata0), 32'(i));
            chk("t2_rempty", 32'(rempty), (i == 15) ? 1 : 0);
        end

        // 3. overflow with simultaneous access at full
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("t3_full", 32'(wfull), 1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("t3_ovf", 32'(ovf), 1);
        chk("t3_count", 32'(count), 15);
        chk("t3_wfull", 32'(wfull), 0);
        chk("t3_reg_data", 32'(rdata0), 32'h40);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_clr", 32'(ovf), 0);
        for (int i = 1; i < 16; i++) begin
            chk("t3_head", 32'(rdata), 32'(8'h40 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t3_drained", 32'(rempty), 1);

        // 4. underflow with simultaneous access at empty; set beats clear
        cyc(1'b1, 8'h3C, 1'b1, 1'b1);
        chk("t4_unf", 32'(unf), 1);
        chk("t4_count", 32'(count), 1);
        chk("t4_rempty", 32'(rempty), 0);
        chk("t4_fwft", 32'(rdata), 32'h3C);
        chk("t4_reg_hold", 32'(rdata0), 32'h4F);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_reg_data", 32'(rdata0), 32'h3C);

        // 5. registered-read latency
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_rd1", 32'(rdata0), 32'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_rd2", 32'(rdata0), 32'h22);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_hold", 32'(rdata0), 32'h22);
        chk("t5_count", 32'(count), 0);

        // 6. wrap-around with a scoreboard
        for (int i = 0; i < 8; i++) begin
            exp_d = 8'($urandom);
            q.push_back(exp_d);
            cyc(1'b1, exp_d, 1'b0, 1'b0);
        end
        nw = 0;
        nr = 0;
        for (int c = 0; c < 400 && (nw < 40 || nr < 40); c++) begin
            do_w = (nw < 40) && (q.size() < 14) && ($urandom_range(0, 1) == 1);
            do_r = (nr < 40) && (q.size() > 3) && ($urandom_range(0, 1) == 1);
            exp_d = 8'($urandom);
            if (do_r) chk("t6_head", 32'(rdata), 32'(q[0]));
            cyc(do_w, exp_d, do_r, 1'b0);
            if (do_r) begin
                chk("t6_reg_data", 32'(rdata0), 32'(q[0]));
                void'(q.pop_front());
                nr++;
            end
            if (do_w) begin
                q.push_back(exp_d);
                nw++;
            end
            chk("t6_count", 32'(count), 32'(q.size()));
            chk("t6_wfull", 32'(wfull), 0);
            chk("t6_rempty", 32'(rempty), 0);
        end
        chk("t6_done", 32'((nw == 40) && (nr == 40)), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
